lpc_ring_ctrl: RTL and testbench

Ring-buffer controller for the LPC sniffer capture RAM. Assigns each captured LPC frame a 6-byte slot, exposed to the frame writer as a 5-bit slot index. Counts committed frames, detects overflow, and streams committed slots out byte-by-byte over a valid/ready byte interface toward the UART transmitter. The RAM read port is shared with the writer, and the writer always has priority.

---
 rtl/lpc_ring_ctrl_pkg.sv | 21 ++
 rtl/lpc_ring_ctrl_if.sv | 9 +
 rtl/lpc_ring_ctrl_reader.sv | 93 +++++++++
 rtl/lpc_ring_ctrl.sv | 116 +++++++++++
 tb/tb_lpc_ring_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lpc_ring_ctrl_pkg.sv
// Shared constants and reader state encoding for the LPC sniffer capture ring.
package lpc_sniffer_pkg;

  localparam int SLOT_BITS  = 5;
  localparam int SLOT_BYTES = 6;

  localparam logic [2:0] OFS_TYPE  = 3'd0;
  localparam logic [2:0] OFS_ADDR0 = 3'd1;
  localparam logic [2:0] OFS_ADDR1 = 3'd2;
  localparam logic [2:0] OFS_ADDR2 = 3'd3;
  localparam logic [2:0] OFS_ADDR3 = 3'd4;
  localparam logic [2:0] OFS_DATA  = 3'd5;

  typedef enum logic [1:0] {
    RD_IDLE    = 2'd0,
    RD_ISSUE   = 2'd1,
    RD_CAPTURE = 2'd2,
    RD_HOLD    = 2'd3
  } rd_state_e;

endpackage

// File: rtl/lpc_ring_ctrl_if.sv
// Byte stream from the ring controller toward the UART transmitter.
interface lpc_ring_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/lpc_ring_ctrl_reader.sv
// Reader FSM: fetches each committed slot byte-by-byte from the shared RAM port
// and presents it on the tx handshake; pulses slot_release after the last byte.
module lpc_ring_reader #(
  parameter int SLOT_BITS  = lpc_sniffer_pkg::SLOT_BITS,
  parameter int SLOT_BYTES = lpc_sniffer_pkg::SLOT_BYTES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 empty,
  input  logic                 wr_ram_active,
  input  logic [SLOT_BITS-1:0] rd_ptr,
  input  logic [7:0]           rd_ram_data,
  output logic                 rd_ram_en,
  output logic [SLOT_BITS+2:0] rd_ram_addr,
  output logic                 slot_release,
  lpc_ring_ctrl_if.master      tx
);
  import lpc_sniffer_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(SLOT_BYTES - 1);

  rd_state_e  state_q, state_d;
  logic [2:0] byte_idx_q, byte_idx_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;

  // Reader state and output registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= RD_IDLE;
      byte_idx_q <= OFS_TYPE;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // Next-state logic; the RAM read waits in ISSUE while the writer owns the port.
  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    rd_ram_en    = 1'b0;
    slot_release = 1'b0;
    case (state_q)
      RD_IDLE: begin
        byte_idx_d = OFS_TYPE;
        if (!empty) state_d = RD_ISSUE;
        else        state_d = RD_IDLE;
      end
      RD_ISSUE: begin
        if (!wr_ram_active) begin
          rd_ram_en = 1'b1;
          state_d   = RD_CAPTURE;
        end else begin
          state_d = RD_ISSUE;
        end
      end
      RD_CAPTURE: begin
        tx_data_d  = rd_ram_data;
        tx_valid_d = 1'b1;
        state_d    = RD_HOLD;
      end
      RD_HOLD: begin
        if (tx_valid_q && tx.tx_ready) begin
          tx_valid_d = 1'b0;
          if (byte_idx_q == LAST_IDX) begin
            slot_release = 1'b1;
            state_d      = RD_IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = RD_ISSUE;
          end
        end else begin
          state_d = RD_HOLD;
        end
      end
      default: begin
        state_d = RD_IDLE;
      end
    endcase
  end

  assign rd_ram_addr = {rd_ptr, byte_idx_q};
  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;

endmodule

// File: rtl/lpc_ring_ctrl.sv
// Capture-RAM ring controller: slot pointers, committed-frame count, overflow
// flag, and the reader that streams committed slots to the transmitter.
module lpc_ring_ctrl #(
  parameter int SLOT_BITS  = lpc_sniffer_pkg::SLOT_BITS,
  parameter int SLOT_BYTES = lpc_sniffer_pkg::SLOT_BYTES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frame_done,
  input  logic                 wr_ram_active,
  output logic [SLOT_BITS-1:0] target_addr,
  output logic                 rd_ram_en,
  output logic [SLOT_BITS+2:0] rd_ram_addr,
  input  logic [7:0]           rd_ram_data,
  output logic [SLOT_BITS:0]   frame_count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  input  logic                 overflow_clr,
  lpc_ring_ctrl_if.master      tx
);
  import lpc_sniffer_pkg::*;

  // One slot stays spare so the writer never lands on a slot still being read.
  localparam logic [SLOT_BITS:0]   FULL_COUNT = {1'b0, {SLOT_BITS{1'b1}}};
  localparam logic [SLOT_BITS:0]   CNT_ONE    = (SLOT_BITS+1)'(1);
  localparam logic [SLOT_BITS-1:0] PTR_ONE    = SLOT_BITS'(1);

  logic [SLOT_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [SLOT_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [SLOT_BITS:0]   count_q, count_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 overflow_q, overflow_d;
  logic                 frame_done_q;
  logic                 commit_s, slot_release_s, ovf_set_s;

  // Ring bookkeeping registers; frame_done history resets high to mask a held level.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q     <= {SLOT_BITS{1'b0}};
      rd_ptr_q     <= {SLOT_BITS{1'b0}};
      count_q      <= {(SLOT_BITS+1){1'b0}};
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done;
    end
  end

  // Commit/release arbitration; a release in the same cycle makes room for a commit.
  always_comb begin
    commit_s   = frame_done && !frame_done_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_set_s  = 1'b0;
    case ({commit_s, slot_release_s})
      2'b11: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      2'b10: begin
        if (!full_q) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          count_d  = count_q + CNT_ONE;
        end else begin
          ovf_set_s = 1'b1;
        end
      end
      2'b01: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        count_d  = count_q - CNT_ONE;
      end
      default: begin
        count_d = count_q;
      end
    endcase
    if (ovf_set_s)         overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
    else                   overflow_d = overflow_q;
    empty_d = (count_d == {(SLOT_BITS+1){1'b0}});
    full_d  = (count_d == FULL_COUNT);
  end

  lpc_ring_reader #(
    .SLOT_BITS  (SLOT_BITS),
    .SLOT_BYTES (SLOT_BYTES)
  ) u_reader (
    .clock         (clock),
    .reset         (reset),
    .empty         (empty_q),
    .wr_ram_active (wr_ram_active),
    .rd_ptr        (rd_ptr_q),
    .rd_ram_data   (rd_ram_data),
    .rd_ram_en     (rd_ram_en),
    .rd_ram_addr   (rd_ram_addr),
    .slot_release  (slot_release_s),
    .tx            (tx)
  );

  assign target_addr = wr_ptr_q;
  assign frame_count = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_lpc_ring_ctrl.sv
// Self-checking bench for lpc_ring_ctrl: RAM model, tx monitor and a byte-FIFO reference.
module tb_lpc_ring_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       frame_done = 1'b1;
  logic       wr_ram_active = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [4:0] target_addr;
  logic       rd_ram_en;
  logic [7:0] rd_ram_addr;
  logic [7:0] rd_ram_data = 8'h00;
  logic [5:0] frame_count;
  logic       empty, full, overflow;

  lpc_ring_ctrl_if tx_if();

  lpc_ring_ctrl #(.SLOT_BITS(5), .SLOT_BYTES(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .frame_done    (frame_done),
    .wr_ram_active (wr_ram_active),
    .target_addr   (target_addr),
    .rd_ram_en     (rd_ram_en),
    .rd_ram_addr   (rd_ram_addr),
    .rd_ram_data   (rd_ram_data),
    .frame_count   (frame_count),
    .empty         (empty),
    .full          (full),
    .overflow      (overflow),
    .overflow_clr  (overflow_clr),
    .tx            (tx_if)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:255];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  int contention_viol = 0;
  int errors = 0;
  int checks = 0;
  int m_wr = 0;
  int m_count = 0;

  always @(posedge clock) begin
    if (rd_ram_en) rd_ram_data <= mem[rd_ram_addr];
  end

  always @(posedge clock) begin
    if (reset && tx_if.tx_valid && tx_if.tx_ready) rx_q.push_back(tx_if.tx_data);
    if (rd_ram_en && wr_ram_active) contention_viol++;
  end

  task automatic reset_dut();
    @(negedge clock);
    reset = 1'b0;
    frame_done = 1'b0;
    tx_if.tx_ready = 1'b0;
    wr_ram_active = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    rx_q.delete();
    exp_q.delete();
    m_wr = 0;
    m_count = 0;
  endtask

  // Writer model: optionally fill the target slot, then pulse frame_done once.
  task automatic commit_frame(input bit rnd);
    @(negedge clock);
    if (rnd) for (int k = 0; k < 6; k++) mem[m_wr*8+k] = 8'($urandom);
    if (m_count < 31) begin
      for (int k = 0; k < 6; k++) exp_q.push_back(mem[m_wr*8+k]);
      m_wr = (m_wr + 1) % 32;
      m_count++;
    end
    frame_done = 1'b1;
    @(negedge clock);
    frame_done = 1'b0;
  endtask

  task automatic wait_bytes(input int n, output bit ok);
    for (int c = 0; c < 400 && rx_q.size() < n; c++) @(negedge clock);
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    tx_if.tx_ready = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (tx_if.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got=%b want=0", tx_if.tx_valid); end
    checks++; if (tx_if.tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got=%h want=00", tx_if.tx_data); end
    checks++; if (rd_ram_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b want=0", rd_ram_en); end
    checks++; if ({empty, full, overflow} !== 3'b100) begin errors++; $display("FAIL rst_flags got=%b want=100", {empty, full, overflow}); end
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (frame_count !== 6'd0) begin errors++; $display("FAIL rst_no_commit count got=%0d want=0", frame_count); end
    checks++; if (target_addr !== 5'd0) begin errors++; $display("FAIL rst_target got=%0d want=0", target_addr); end
    frame_done = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single_frame();
    logic [7:0] sf [6];
    logic [7:0] got;
    int cyc;
    bit ok;
    sf = '{8'h02, 8'hFE, 8'hD0, 8'h00, 8'h80, 8'h5A};
    for (int k = 0; k < 6; k++) mem[k] = sf[k];
    tx_if.tx_ready = 1'b1;
    commit_frame(1'b0);
    checks++; if (target_addr !== 5'd1) begin errors++; $display("FAIL single_target got=%0d want=1", target_addr); end
    checks++; if (frame_count !== 6'd1) begin errors++; $display("FAIL single_count got=%0d want=1", frame_count); end
    cyc = 0;
    while (!empty && cyc < 100) begin @(negedge clock); cyc++; end
    checks++; if (cyc !== 19) begin errors++; $display("FAIL single_latency cycles got=%0d want=19", cyc); end
    wait_bytes(6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_bytes got=%0d want=6", rx_q.size()); end
    for (int k = 0; k < 6 && rx_q.size() > 0; k++) begin
      got = rx_q.pop_front();
      void'(exp_q.pop_front());
      checks++; if (got !== sf[k]) begin errors++; $display("FAIL single_byte%0d got=%h want=%h", k, got, sf[k]); end
    end
    m_count--;
    checks++; if (frame_count !== 6'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_drained count=%0d empty=%b want 0/1", frame_count, empty); end
  endtask

  task automatic test_contention();
    logic [7:0] got, want;
    bit ok;
    @(negedge clock);
    wr_ram_active = 1'b1;
    tx_if.tx_ready = 1'b1;
    commit_frame(1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++; if (rd_ram_en !== 1'b0) begin errors++; $display("FAIL contend_stall c=%0d rd_en got=%b want=0", c, rd_ram_en); end
    end
    @(negedge clock);
    wr_ram_active = 1'b0;
    #1;
    checks++; if (rd_ram_en !== 1'b1 || rd_ram_addr !== 8'h08) begin errors++; $display("FAIL contend_issue rd_en=%b addr=%h want 1/08", rd_ram_en, rd_ram_addr); end
    wait_bytes(6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL contend_bytes got=%0d want=6", rx_q.size()); end
    for (int k = 0; k < 6 && rx_q.size() > 0 && exp_q.size() > 0; k++) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL contend_byte%0d got=%h want=%h", k, got, want); end
    end
    m_count--;
    checks++; if (contention_viol !== 0) begin errors++; $display("FAIL contend_viol got=%0d want=0", contention_viol); end
  endtask

  task automatic test_backpressure();
    logic [7:0] held, got, want;
    int c;
    bit ok;
    @(negedge clock);
    tx_if.tx_ready = 1'b0;
    commit_frame(1'b1);
    c = 0;
    while (!tx_if.tx_valid && c < 20) begin @(negedge clock); c++; end
    checks++; if (tx_if.tx_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_timeout got=%b want=1", tx_if.tx_valid); end
    held = tx_if.tx_data;
    checks++; if (held !== exp_q[0]) begin errors++; $display("FAIL bp_first got=%h want=%h", held, exp_q[0]); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      checks++; if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== held || rd_ram_en !== 1'b0) begin
        errors++; $display("FAIL bp_hold k=%0d valid=%b data=%h rd_en=%b want 1/%h/0", k, tx_if.tx_valid, tx_if.tx_data, rd_ram_en, held);
      end
    end
    tx_if.tx_ready = 1'b1;
    wait_bytes(6, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_bytes got=%0d want=6", rx_q.size()); end
    for (int k = 0; k < 6 && rx_q.size() > 0 && exp_q.size() > 0; k++) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL bp_byte%0d got=%h want=%h", k, got, want); end
    end
    m_count--;
  endtask

  task automatic test_random();
    logic [7:0] got, want;
    int rx_total = 0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      @(negedge clock);
      tx_if.tx_ready = (cyc >= 500) ? 1'b1 : ($urandom_range(0, 3) != 0);
      wr_ram_active  = (cyc >= 500) ? 1'b0 : ($urandom_range(0, 2) == 0);
      if (frame_done) begin
        frame_done = 1'b0;
      end else if (cyc < 480 && m_count < 6 && $urandom_range(0, 5) == 0) begin
        for (int k = 0; k < 6; k++) begin
          mem[m_wr*8+k] = 8'($urandom);
          exp_q.push_back(mem[m_wr*8+k]);
        end
        m_wr = (m_wr + 1) % 32;
        m_count++;
        frame_done = 1'b1;
      end
      while (rx_q.size() > 0) begin
        got = rx_q.pop_front();
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++; if (got !== want) begin errors++; $display("FAIL rand_byte%0d got=%h want=%h", rx_total, got, want); end
        rx_total++;
        if (rx_total % 6 == 0) m_count--;
      end
    end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL rand_drain left=%0d want=0", exp_q.size()); end
    checks++; if (frame_count !== 6'(m_count) || empty !== 1'b1) begin errors++; $display("FAIL rand_count got=%0d/%b want=%0d/1", frame_count, empty, m_count); end
    checks++; if (target_addr !== 5'(m_wr)) begin errors++; $display("FAIL rand_target got=%0d want=%0d", target_addr, m_wr); end
    checks++; if (contention_viol !== 0) begin errors++; $display("FAIL rand_contention got=%0d want=0", contention_viol); end
  endtask

  task automatic test_overflow();
    reset_dut();
    for (int i = 0; i < 31; i++) commit_frame(1'b1);
    checks++; if (frame_count !== 6'd31 || full !== 1'b1 || overflow !== 1'b0 || empty !== 1'b0) begin
      errors++; $display("FAIL ovf_full count=%0d full=%b ovf=%b empty=%b want 31/1/0/0", frame_count, full, overflow, empty);
    end
    checks++; if (target_addr !== 5'd31) begin errors++; $display("FAIL ovf_target31 got=%0d want=31", target_addr); end
    commit_frame(1'b1);
    checks++; if (overflow !== 1'b1 || target_addr !== 5'd31 || frame_count !== 6'd31) begin
      errors++; $display("FAIL ovf_drop ovf=%b target=%0d count=%0d want 1/31/31", overflow, target_addr, frame_count);
    end
    @(negedge clock); overflow_clr = 1'b1;
    @(negedge clock); overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    @(negedge clock); frame_done = 1'b1; overflow_clr = 1'b1;
    @(negedge clock); frame_done = 1'b0; overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b want=1", overflow); end
    @(negedge clock); overflow_clr = 1'b1;
    @(negedge clock); overflow_clr = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear2 got=%b want=0", overflow); end
  endtask

  task automatic test_wrap();
    logic [7:0] got, want;
    int got_n = 0;
    bit done = 1'b0;
    int c;
    for (c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      tx_if.tx_ready = 1'b0;
      if (tx_if.tx_valid) begin
        if (got_n < 5) begin
          tx_if.tx_ready = 1'b1;
          got_n++;
        end else begin
          for (int k = 0; k < 6; k++) mem[m_wr*8+k] = 8'($urandom);
          tx_if.tx_ready = 1'b1;
          frame_done = 1'b1;
          done = 1'b1;
        end
      end
    end
    @(negedge clock);
    frame_done = 1'b0;
    tx_if.tx_ready = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL wrap_timeout bytes=%0d want=5", got_n); end
    checks++; if (overflow !== 1'b0 || frame_count !== 6'd31 || full !== 1'b1) begin
      errors++; $display("FAIL wrap_flags ovf=%b count=%0d full=%b want 0/31/1", overflow, frame_count, full);
    end
    checks++; if (target_addr !== 5'd0) begin errors++; $display("FAIL wrap_target got=%0d want=0", target_addr); end
    for (int k = 0; k < 6 && rx_q.size() > 0 && exp_q.size() > 0; k++) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL wrap_byte%0d got=%h want=%h", k, got, want); end
    end
    for (int k = 0; k < 6; k++) exp_q.push_back(mem[31*8+k]);
    m_wr = 0;
    c = 0;
    while (!rd_ram_en && c < 10) begin @(negedge clock); c++; end
    checks++; if (rd_ram_en !== 1'b1 || rd_ram_addr !== 8'h08) begin
      errors++; $display("FAIL wrap_next_read rd_en=%b addr=%h want 1/08", rd_ram_en, rd_ram_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, want;
    int got_n = 0;
    bit done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clock);
      tx_if.tx_ready = 1'b0;
      if (tx_if.tx_valid) begin
        if (got_n < 3) begin
          tx_if.tx_ready = 1'b1;
          got_n++;
        end else begin
          reset = 1'b0;
          done = 1'b1;
        end
      end
    end
    @(negedge clock);
    checks++; if (!done) begin errors++; $display("FAIL rmid_timeout bytes=%0d want=3", got_n); end
    checks++; if (tx_if.tx_valid !== 1'b0 || frame_count !== 6'd0 || target_addr !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL rmid_state valid=%b count=%0d target=%0d empty=%b full=%b want 0/0/0/1/0",
                         tx_if.tx_valid, frame_count, target_addr, empty, full);
    end
    for (int k = 0; k < 3 && rx_q.size() > 0 && exp_q.size() > 0; k++) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL rmid_byte%0d got=%h want=%h", k, got, want); end
    end
    reset = 1'b1;
    rx_q.delete(); exp_q.delete(); m_wr = 0; m_count = 0;
    repeat (3) @(negedge clock);
    checks++; if (rd_ram_en !== 1'b0 || tx_if.tx_valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL rmid_idle rd_en=%b valid=%b empty=%b want 0/0/1", rd_ram_en, tx_if.tx_valid, empty);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tx_if.tx_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_contention();
    test_backpressure();
    test_random();
    test_overflow();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
